cam_capture_ctrl: RTL and testbench



---
 rtl/cam_capture_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: camera front-end for the Mico32 camera platforms.
// Drives the sensor control pins, oversamples the sensor's parallel pixel bus in the clk_i
// domain, packs accepted pixels into WORD_W-bit words and buffers them in a
// first-word-fall-through FIFO for the DMA/bus slave.
//
// Ports:
//   clk_i, rst_i                      platform clock, synchronous active-high reset
//   enable_i                          capture enable
//   decim_i[1:0]                      0: every pixel/line, 1: every 2nd, 2/3: every 4th
//   clear_ovf_i                       clears the sticky overflow flag
//   cam_y_i, cam_pclk_i,
//   cam_hsync_i, cam_vsync_i          asynchronous sensor bus
//   cam_mclk_o, cam_rst_o, cam_enb_o  sensor master clock, reset (active low), enable
//   data_o, sof_o, valid_o, ready_i   FIFO head word, start-of-frame marker, handshake
//   overflow_o                        sticky: a word was dropped on a full FIFO
//   frame_cnt_o                       completed frame count, wraps
module cam_capture_ctrl #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MCLK_DIV   = 1,
  parameter int unsigned RST_HOLD   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [1:0]        decim_i,
  input  logic              clear_ovf_i,
  input  logic [PIX_W-1:0]  cam_y_i,
  input  logic              cam_pclk_i,
  input  logic              cam_hsync_i,
  input  logic              cam_vsync_i,
  output logic              cam_mclk_o,
  output logic              cam_rst_o,
  output logic              cam_enb_o,
  output logic [WORD_W-1:0] data_o,
  output logic              sof_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overflow_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int unsigned PPW    = WORD_W / PIX_W;
  localparam int unsigned LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned MCLK_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

  localparam logic [1:0] StHold    = 2'd0;
  localparam logic [1:0] StIdle    = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StCapture = 2'd3;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic             pclk_s1_q, pclk_s2_q, pclk_prev_q;
  logic             hs_s1_q, hs_s2_q, hs_prev_q;
  logic             vs_s1_q, vs_s2_q, vs_prev_q;
  logic [PIX_W-1:0] y_s1_q, y_s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pclk_s1_q   <= 1'b0;
      pclk_s2_q   <= 1'b0;
      pclk_prev_q <= 1'b0;
      hs_s1_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      hs_prev_q   <= 1'b0;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_prev_q   <= 1'b0;
      y_s1_q      <= '0;
      y_s2_q      <= '0;
    end else begin
      pclk_s1_q   <= cam_pclk_i;
      pclk_s2_q   <= pclk_s1_q;
      pclk_prev_q <= pclk_s2_q;
      hs_s1_q     <= cam_hsync_i;
      hs_s2_q     <= hs_s1_q;
      hs_prev_q   <= hs_s2_q;
      vs_s1_q     <= cam_vsync_i;
      vs_s2_q     <= vs_s1_q;
      vs_prev_q   <= vs_s2_q;
      y_s1_q      <= cam_y_i;
      y_s2_q      <= y_s1_q;
    end
  end

  logic pclk_rise, hs_fall, vs_fall, vs_rise;
  assign pclk_rise = pclk_s2_q & ~pclk_prev_q;
  assign hs_fall   = hs_prev_q & ~hs_s2_q;
  assign vs_fall   = vs_prev_q & ~vs_s2_q;
  assign vs_rise   = vs_s2_q & ~vs_prev_q;

  // ---------------------------------------------------------------------------
  // Control state machine
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              enter_capt, frame_done;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    enter_capt = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      StHold: begin
        // Counter starts at 0 on the first edge out of reset, so the exit edge is
        // exactly RST_HOLD edges later.
        if (hold_cnt_q == HOLD_W'(RST_HOLD)) state_d = StIdle;
        else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      StIdle: begin
        if (enable_i) state_d = StWait;
      end
      StWait: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (vs_fall) begin
          state_d    = StCapture;
          enter_capt = 1'b1;
        end
      end
      default: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          state_d    = StWait;
          frame_done = 1'b1;
        end
      end
    endcase
  end

  logic [1:0]  decim_q;
  logic        frame_inc_q;
  logic [15:0] frame_cnt_q;
  logic        enb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      decim_q     <= 2'd0;
      frame_inc_q <= 1'b0;
      frame_cnt_q <= '0;
      enb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      frame_inc_q <= frame_done;
      enb_q       <= (state_q != StHold) & enable_i;
      if (enter_capt) decim_q <= (decim_i == 2'd3) ? 2'd2 : decim_i;
      if (frame_inc_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign cam_rst_o   = (state_q != StHold);
  assign cam_enb_o   = enb_q;
  assign frame_cnt_o = frame_cnt_q;

  // ---------------------------------------------------------------------------
  // Sensor master clock
  // ---------------------------------------------------------------------------
  logic              mclk_q;
  logic [MCLK_W-1:0] mclk_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mclk_q     <= 1'b0;
      mclk_cnt_q <= '0;
    end else if (mclk_cnt_q == MCLK_W'(MCLK_DIV - 1)) begin
      mclk_q     <= ~mclk_q;
      mclk_cnt_q <= '0;
    end else begin
      mclk_cnt_q <= mclk_cnt_q + MCLK_W'(1);
    end
  end

  assign cam_mclk_o = mclk_q;

  // ---------------------------------------------------------------------------
  // Pixel accept (decimation) - stage 1
  // ---------------------------------------------------------------------------
  logic             capt_live;
  logic [1:0]       pix_ph_q, line_ph_q, decim_mask;
  logic             accept;
  logic             acc_q, flush_q;
  logic [PIX_W-1:0] pix_q;

  assign capt_live  = (state_q == StCapture) & enable_i;
  assign decim_mask = (decim_q == 2'd0) ? 2'b00 : (decim_q == 2'd1) ? 2'b01 : 2'b11;
  assign accept     = capt_live & pclk_rise & hs_s2_q &
                      ((pix_ph_q & decim_mask) == 2'b00) &
                      ((line_ph_q & decim_mask) == 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_ph_q  <= 2'd0;
      line_ph_q <= 2'd0;
      acc_q     <= 1'b0;
      flush_q   <= 1'b0;
      pix_q     <= '0;
    end else begin
      acc_q   <= accept;
      flush_q <= capt_live & hs_fall;
      pix_q   <= y_s2_q;
      if (enter_capt) begin
        pix_ph_q  <= 2'd0;
        line_ph_q <= 2'd0;
      end else if (capt_live) begin
        if (hs_fall) begin
          pix_ph_q  <= 2'd0;
          line_ph_q <= line_ph_q + 2'd1;
        end else if (pclk_rise && hs_s2_q) begin
          pix_ph_q <= pix_ph_q + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packing - stage 2
  // ---------------------------------------------------------------------------
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] pack_q, pack_d, pack_ins;
  logic              sof_pend_q, sof_pend_d;
  logic              push_d, push_q;
  logic [WORD_W-1:0] push_word_d, push_word_q;
  logic              push_sof_q;
  logic              pack_clr;

  // Anything that is not a live capture throws the partial word away.
  assign pack_clr = ~enable_i | (state_q == StHold) | (state_q == StIdle);

  always_comb begin
    lane_d      = lane_q;
    pack_d      = pack_q;
    sof_pend_d  = sof_pend_q;
    push_d      = 1'b0;
    push_word_d = pack_q;
    pack_ins    = pack_q;
    pack_ins[lane_q*PIX_W +: PIX_W] = pix_q;
    if (enter_capt) begin
      lane_d     = '0;
      pack_d     = '0;
      sof_pend_d = 1'b1;
    end else if (pack_clr) begin
      lane_d = '0;
      pack_d = '0;
    end else if (acc_q) begin
      if (lane_q == LANE_W'(PPW - 1)) begin
        push_d      = 1'b1;
        push_word_d = pack_ins;
        pack_d      = '0;
        lane_d      = '0;
        sof_pend_d  = 1'b0;
      end else begin
        pack_d = pack_ins;
        lane_d = lane_q + LANE_W'(1);
      end
    end else if (flush_q && (lane_q != '0)) begin
      // Unused upper lanes are already zero since pack_q is cleared on every push.
      push_d      = 1'b1;
      push_word_d = pack_q;
      pack_d      = '0;
      lane_d      = '0;
      sof_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q      <= '0;
      pack_q      <= '0;
      sof_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      push_sof_q  <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      sof_pend_q  <= sof_pend_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      push_sof_q  <= sof_pend_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through), entries are {sof, word}
  // ---------------------------------------------------------------------------
  logic [WORD_W:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, pop, wr_en, ovf_q;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = valid_o & ready_i;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign wr_en   = push_q & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= {push_sof_q, push_word_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // Set wins over clear.
      if (push_q && !wr_en) ovf_q <= 1'b1;
      else if (clear_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign data_o     = valid_o ? mem[rd_ptr_q][WORD_W-1:0] : '0;
  assign sof_o      = valid_o ? mem[rd_ptr_q][WORD_W] : 1'b0;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl: stimulus pushes expected {sof, word} entries,
// a negedge monitor pops and compares on every valid_o & ready_i handshake.
module tb_cam_capture_ctrl;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MCLK_DIV   = 1;
  localparam int unsigned RST_HOLD   = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              enable_i = 1'b0;
  logic [1:0]        decim_i = 2'd0;
  logic              clear_ovf_i = 1'b0;
  logic [PIX_W-1:0]  cam_y_i = '0;
  logic              cam_pclk_i = 1'b0;
  logic              cam_hsync_i = 1'b0;
  logic              cam_vsync_i = 1'b1;
  logic              cam_mclk_o, cam_rst_o, cam_enb_o;
  logic [WORD_W-1:0] data_o;
  logic              sof_o, valid_o, overflow_o;
  logic              ready_i = 1'b1;
  logic [15:0]       frame_cnt_o;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  cam_capture_ctrl #(
    .PIX_W     (PIX_W),
    .WORD_W    (WORD_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MCLK_DIV  (MCLK_DIV),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .decim_i    (decim_i),
    .clear_ovf_i(clear_ovf_i),
    .cam_y_i    (cam_y_i),
    .cam_pclk_i (cam_pclk_i),
    .cam_hsync_i(cam_hsync_i),
    .cam_vsync_i(cam_vsync_i),
    .cam_mclk_o (cam_mclk_o),
    .cam_rst_o  (cam_rst_o),
    .cam_enb_o  (cam_enb_o),
    .data_o     (data_o),
    .sof_o      (sof_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got sof=%0d data=0x%08h, expected no word", sof_o, data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", data_o, mon_e[31:0]);
        check("word_sof", {31'd0, sof_o}, {31'd0, mon_e[32]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_word(input logic sof, input logic [31:0] w);
    exp_q.push_back({sof, w});
  endtask

  task automatic pix(input logic [7:0] v);
    cam_pclk_i = 1'b0;
    cam_y_i    = v;
    tick(4);
    cam_pclk_i = 1'b1;
    tick(4);
  endtask

  task automatic send_line(input logic [7:0] base, input int n);
    cam_hsync_i = 1'b1;
    tick(4);
    for (int i = 0; i < n; i++) pix(base + 8'(i));
    cam_pclk_i = 1'b0;
    tick(4);
    cam_hsync_i = 1'b0;
    tick(8);
  endtask

  task automatic vs_fall();
    cam_vsync_i = 1'b0;
    tick(8);
  endtask

  task automatic vs_rise();
    cam_vsync_i = 1'b1;
    tick(8);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      tick(1);
      t++;
    end
    check("drain_pending_words", exp_q.size(), 0);
    tick(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(1);
    check("rst_mclk", {31'd0, cam_mclk_o}, 0);
    check("rst_cam_rst", {31'd0, cam_rst_o}, 0);
    check("rst_enb", {31'd0, cam_enb_o}, 0);
    check("rst_data", data_o, 0);
    check("rst_sof", {31'd0, sof_o}, 0);
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_overflow", {31'd0, overflow_o}, 0);
    check("rst_frame_cnt", {16'd0, frame_cnt_o}, 0);
    tick(2);
    rst_i = 1'b0;

    // Sensor reset hold and master clock
    for (int k = 0; k <= 16; k++) begin
      tick(1);
      check($sformatf("hold_cam_rst_k%0d", k), {31'd0, cam_rst_o}, (k >= 16) ? 1 : 0);
      check($sformatf("mclk_k%0d", k), {31'd0, cam_mclk_o}, (k % 2 == 0) ? 1 : 0);
    end

    enable_i = 1'b1;
    tick(2);
    check("enb_on", {31'd0, cam_enb_o}, 1);

    // Packing: 8 pixels -> 2 full words
    expect_word(1'b1, 32'h04030201);
    expect_word(1'b0, 32'h08070605);
    vs_fall();
    send_line(8'h01, 8);
    vs_rise();
    drain();
    check("frame_cnt_1", {16'd0, frame_cnt_o}, 1);

    // Partial word zero-filled at hsync fall
    expect_word(1'b1, 32'hA4A3A2A1);
    expect_word(1'b0, 32'h0000A6A5);
    vs_fall();
    send_line(8'hA1, 6);
    vs_rise();
    drain();
    check("frame_cnt_2", {16'd0, frame_cnt_o}, 2);

    // Decimation by 2: lines 0 and 2, even pixels
    decim_i = 2'd1;
    expect_word(1'b1, 32'h06040200);
    expect_word(1'b0, 32'h26242220);
    vs_fall();
    for (int l = 0; l < 4; l++) send_line(8'(l * 16), 8);
    vs_rise();
    drain();
    check("frame_cnt_3", {16'd0, frame_cnt_o}, 3);

    // decim 3 behaves as 4: line 0 pixels 0 and 4 only, flushed as a partial word
    decim_i = 2'd3;
    expect_word(1'b1, 32'h00000400);
    vs_fall();
    decim_i = 2'd0;
    for (int l = 0; l < 4; l++) send_line(8'(l * 16), 8);
    vs_rise();
    drain();
    check("frame_cnt_4", {16'd0, frame_cnt_o}, 4);

    // Overflow: 6 words into a 4-deep FIFO with the consumer stalled
    ready_i = 1'b0;
    expect_word(1'b1, 32'h13121110);
    expect_word(1'b0, 32'h17161514);
    expect_word(1'b0, 32'h23222120);
    expect_word(1'b0, 32'h27262524);
    vs_fall();
    send_line(8'h10, 8);
    send_line(8'h20, 8);
    send_line(8'h30, 8);
    vs_rise();
    check("ovf_set", {31'd0, overflow_o}, 1);
    check("ovf_valid_held", {31'd0, valid_o}, 1);
    check("ovf_head_data", data_o, 32'h13121110);
    check("ovf_head_sof", {31'd0, sof_o}, 1);
    tick(3);
    check("stall_data_stable", data_o, 32'h13121110);
    ready_i = 1'b1;
    drain();
    check("ovf_empty_after_drain", {31'd0, valid_o}, 0);
    check("ovf_sticky", {31'd0, overflow_o}, 1);
    clear_ovf_i = 1'b1;
    tick(1);
    clear_ovf_i = 1'b0;
    check("ovf_cleared", {31'd0, overflow_o}, 0);
    check("frame_cnt_5", {16'd0, frame_cnt_o}, 5);

    // Disable mid-frame after 3 pixels: partial word discarded
    vs_fall();
    cam_hsync_i = 1'b1;
    tick(4);
    pix(8'h51);
    pix(8'h52);
    pix(8'h53);
    cam_pclk_i = 1'b0;
    tick(4);
    enable_i = 1'b0;
    tick(2);
    check("disable_enb_off", {31'd0, cam_enb_o}, 0);
    tick(8);
    cam_hsync_i = 1'b0;
    tick(8);
    vs_rise();
    check("disable_no_word", {31'd0, valid_o}, 0);
    check("disable_frame_cnt", {16'd0, frame_cnt_o}, 5);
    enable_i = 1'b1;
    tick(2);
    expect_word(1'b1, 32'h64636261);
    vs_fall();
    send_line(8'h61, 4);
    vs_rise();
    drain();
    check("frame_cnt_6", {16'd0, frame_cnt_o}, 6);

    // Reset mid-frame flushes the FIFO and clears everything
    ready_i = 1'b0;
    vs_fall();
    send_line(8'h71, 4);
    check("pre_reset_valid", {31'd0, valid_o}, 1);
    rst_i = 1'b1;
    tick(1);
    check("midrst_valid", {31'd0, valid_o}, 0);
    check("midrst_data", data_o, 0);
    check("midrst_cam_rst", {31'd0, cam_rst_o}, 0);
    check("midrst_enb", {31'd0, cam_enb_o}, 0);
    check("midrst_frame_cnt", {16'd0, frame_cnt_o}, 0);
    check("midrst_mclk", {31'd0, cam_mclk_o}, 0);
    rst_i = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
